// File: rtl/ctrl_seq.sv
// ctrl_seq: instruction sequencer for a small accumulator datapath.
// The block accepts one instruction in IDLE, then walks EXEC -> (MEM) -> WB and
// returns to IDLE. It drives register-file addresses, ALU operation fields and
// memory strobes. Strobes and status outputs are registered. ALU and address
// fields are decoded directly from the held instruction register.
module ctrl_seq #(
  parameter int IW  = 9,
  parameter int ACC = 0
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [IW-1:0] inst,
  input  logic          inst_valid,
  output logic          inst_ready,
  input  logic          zero,
  input  logic          mem_ack,
  output logic [IW-5:0] rAddrA,
  output logic [IW-5:0] rAddrB,
  output logic [IW-5:0] wAddr,
  output logic          write_en,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic          jump_en,
  output logic [1:0]    OP,
  output logic [1:0]    funct,
  output logic          zero_flag,
  output logic          busy
);

  localparam int AW = IW - 4;

  localparam logic [2:0] OPC_ALU0  = 3'b000;
  localparam logic [2:0] OPC_ALU1  = 3'b001;
  localparam logic [2:0] OPC_STORE = 3'b010;
  localparam logic [2:0] OPC_LOAD  = 3'b011;
  localparam logic [2:0] OPC_JUMP  = 3'b100;
  localparam logic [2:0] OPC_CMP   = 3'b101;
  localparam logic [2:0] OPC_BRE   = 3'b110;
  localparam logic [2:0] OPC_MOV   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] ir;
  logic          cap;        // zero flag captured in EXEC of a CMP
  logic [2:0]    opc;
  logic          is_load;
  logic          is_store;
  logic          writes_reg;

  // Decode of the held instruction; valid in every state after an accept.
  assign opc        = ir[IW-1:IW-3];
  assign is_load    = (opc == OPC_LOAD);
  assign is_store   = (opc == OPC_STORE);
  assign writes_reg = (opc == OPC_ALU0) || (opc == OPC_ALU1) ||
                      (opc == OPC_LOAD) || (opc == OPC_MOV);

  assign OP     = ir[IW-1:IW-2];
  assign funct  = (ir[IW-1:IW-2] == 2'b00) ? ir[IW-3:IW-4] : {1'b0, ir[IW-3]};
  assign rAddrB = ir[AW-1:0];
  assign rAddrA = AW'(ACC);
  assign wAddr  = AW'(ACC);

  // Sequencer state, instruction register and all registered strobes/status.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      ir         <= '0;
      cap        <= 1'b0;
      zero_flag  <= 1'b0;
      inst_ready <= 1'b1;
      busy       <= 1'b0;
      write_en   <= 1'b0;
      ReadMem    <= 1'b0;
      WriteMem   <= 1'b0;
      jump_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          write_en <= 1'b0;
          ReadMem  <= 1'b0;
          WriteMem <= 1'b0;
          jump_en  <= 1'b0;
          if (inst_valid) begin
            ir         <= inst;
            state      <= EXEC;
            inst_ready <= 1'b0;
            busy       <= 1'b1;
          end else begin
            inst_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end

        EXEC: begin
          if (opc == OPC_CMP) begin
            cap <= zero;
          end else begin
            cap <= cap;
          end
          if (is_load || is_store) begin
            state    <= MEM;
            ReadMem  <= is_load;
            WriteMem <= is_store;
            write_en <= 1'b0;
            jump_en  <= 1'b0;
          end else begin
            // Strobes are raised here so they are high during the WB cycle.
            state    <= WB;
            write_en <= writes_reg;
            jump_en  <= (opc == OPC_JUMP) || ((opc == OPC_BRE) && zero_flag);
          end
        end

        MEM: begin
          if (mem_ack) begin
            ReadMem  <= 1'b0;
            WriteMem <= 1'b0;
            if (is_load) begin
              state    <= WB;
              write_en <= 1'b1;
            end else begin
              state      <= IDLE;
              inst_ready <= 1'b1;
              busy       <= 1'b0;
            end
          end else begin
            state <= MEM;
          end
        end

        WB: begin
          write_en   <= 1'b0;
          jump_en    <= 1'b0;
          state      <= IDLE;
          inst_ready <= 1'b1;
          busy       <= 1'b0;
          if (opc == OPC_CMP) begin
            zero_flag <= cap;
          end else begin
            zero_flag <= zero_flag;
          end
        end

        default: begin
          state      <= IDLE;
          inst_ready <= 1'b1;
          busy       <= 1'b0;
          write_en   <= 1'b0;
          ReadMem    <= 1'b0;
          WriteMem   <= 1'b0;
          jump_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed testbench for ctrl_seq (IW = 9, ACC = 0) with hand-computed expectations.
module tb_ctrl_seq;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [8:0] inst;
  logic       inst_valid;
  logic       inst_ready;
  logic       zero;
  logic       mem_ack;
  logic [4:0] rAddrA, rAddrB, wAddr;
  logic       write_en, ReadMem, WriteMem, jump_en;
  logic [1:0] OP, funct;
  logic       zero_flag, busy;

  int total = 0;
  int bad   = 0;

  ctrl_seq #(.IW(9), .ACC(0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .zero(zero), .mem_ack(mem_ack),
    .rAddrA(rAddrA), .rAddrB(rAddrB), .wAddr(wAddr), .write_en(write_en),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .jump_en(jump_en),
    .OP(OP), .funct(funct), .zero_flag(zero_flag), .busy(busy)
  );

  // Free-running clock, period 10.
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Offer an instruction in the current (IDLE) cycle; returns in EXEC.
  task automatic issue(input logic [8:0] i);
    inst       = i;
    inst_valid = 1'b1;
    check_val("ready_before_accept", 32'(inst_ready), 32'd1);
    tick();
    inst_valid = 1'b0;
    check_val("busy_exec", 32'(busy), 32'd1);
    check_val("ready_exec", 32'(inst_ready), 32'd0);
  endtask

  // Run a non-memory op from EXEC through WB back to IDLE.
  task automatic run_wb(input string tag, input logic we_exp, input logic jmp_exp);
    check_val({tag, "_we_exec"}, 32'(write_en), 32'd0);
    check_val({tag, "_jmp_exec"}, 32'(jump_en), 32'd0);
    tick();
    check_val({tag, "_we_wb"}, 32'(write_en), 32'(we_exp));
    check_val({tag, "_jmp_wb"}, 32'(jump_en), 32'(jmp_exp));
    tick();
    check_val({tag, "_we_idle"}, 32'(write_en), 32'd0);
    check_val({tag, "_jmp_idle"}, 32'(jump_en), 32'd0);
    check_val({tag, "_ready_idle"}, 32'(inst_ready), 32'd1);
  endtask

  initial begin
    Reset_n    = 1'b0;
    inst       = 9'd0;
    inst_valid = 1'b0;
    zero       = 1'b0;
    mem_ack    = 1'b0;
    #12;
    check_val("rst_ready", 32'(inst_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_strobes", {28'd0, write_en, ReadMem, WriteMem, jump_en}, 32'd0);
    check_val("rst_zf", 32'(zero_flag), 32'd0);
    check_val("rst_fields", {22'd0, OP, funct, rAddrB, wAddr}, 32'd0);
    Reset_n = 1'b1;
    tick();

    // ALU: OP=00 funct=01 rAddrB=3, write_en only in WB (cycle 2).
    issue(9'b0_0010_0011);
    check_val("alu_op", 32'(OP), 32'd0);
    check_val("alu_funct", 32'(funct), 32'd1);
    check_val("alu_rb", 32'(rAddrB), 32'd3);
    check_val("alu_ra", 32'(rAddrA), 32'd0);
    check_val("alu_wa", 32'(wAddr), 32'd0);
    run_wb("alu", 1'b1, 1'b0);

    // LOAD: ack in 3rd MEM cycle, so ReadMem is high for 3 cycles, then WB.
    issue(9'b011_0_00101);
    check_val("ld_op", 32'(OP), 32'd1);
    check_val("ld_funct", 32'(funct), 32'd1);
    check_val("ld_rm_exec", 32'(ReadMem), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_val("ld_rm_mem", 32'(ReadMem), 32'd1);
      check_val("ld_we_mem", 32'(write_en), 32'd0);
      mem_ack = (c == 3) ? 1'b1 : 1'b0;
    end
    tick();
    mem_ack = 1'b0;
    check_val("ld_rm_wb", 32'(ReadMem), 32'd0);
    check_val("ld_we_wb", 32'(write_en), 32'd1);
    check_val("ld_rb_wb", 32'(rAddrB), 32'd5);
    tick();
    check_val("ld_we_idle", 32'(write_en), 32'd0);
    check_val("ld_ready_idle", 32'(inst_ready), 32'd1);

    // STORE: ack in 1st MEM cycle, back to IDLE next cycle, never writes.
    issue(9'b010_0_00111);
    check_val("st_wm_exec", 32'(WriteMem), 32'd0);
    tick();
    check_val("st_wm_mem", 32'(WriteMem), 32'd1);
    check_val("st_rm_mem", 32'(ReadMem), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_val("st_wm_idle", 32'(WriteMem), 32'd0);
    check_val("st_we_idle", 32'(write_en), 32'd0);
    check_val("st_ready_idle", 32'(inst_ready), 32'd1);

    // CMP zero=1 then BRE taken.
    zero = 1'b1;
    issue(9'b101_0_00000);
    check_val("cmp_op", 32'(OP), 32'd2);
    check_val("cmp_funct", 32'(funct), 32'd1);
    run_wb("cmp1", 1'b0, 1'b0);
    zero = 1'b0;
    check_val("cmp1_zf", 32'(zero_flag), 32'd1);
    issue(9'b110_0_00000);
    run_wb("bre1", 1'b0, 1'b1);
    check_val("bre1_zf", 32'(zero_flag), 32'd1);

    // CMP zero=0 then BRE not taken.
    issue(9'b101_0_00000);
    run_wb("cmp0", 1'b0, 1'b0);
    check_val("cmp0_zf", 32'(zero_flag), 32'd0);
    issue(9'b110_0_00000);
    run_wb("bre0", 1'b0, 1'b0);

    // JUMP always redirects; MOV writes.
    issue(9'b100_0_00001);
    run_wb("jump", 1'b0, 1'b1);
    issue(9'b111_0_01001);
    check_val("mov_funct", 32'(funct), 32'd1);
    check_val("mov_rb", 32'(rAddrB), 32'd9);
    run_wb("mov", 1'b1, 1'b0);

    // Reset mid-MEM of a LOAD with inst_valid held high.
    zero = 1'b1;
    issue(9'b101_0_00000);
    run_wb("cmp_pre", 1'b0, 1'b0);
    zero = 1'b0;
    check_val("pre_rst_zf", 32'(zero_flag), 32'd1);
    issue(9'b011_0_00101);
    inst_valid = 1'b1;
    tick();
    check_val("rst_ld_rm", 32'(ReadMem), 32'd1);
    #3;
    Reset_n = 1'b0;
    #1;
    check_val("rst_async_rm", 32'(ReadMem), 32'd0);
    check_val("rst_async_zf", 32'(zero_flag), 32'd0);
    check_val("rst_async_ready", 32'(inst_ready), 32'd1);
    check_val("rst_async_busy", 32'(busy), 32'd0);
    tick();
    check_val("rst_hold_busy", 32'(busy), 32'd0);
    check_val("rst_hold_we", 32'(write_en), 32'd0);
    #2;
    Reset_n = 1'b1;
    tick();
    inst_valid = 1'b0;
    check_val("reaccept_busy", 32'(busy), 32'd1);
    check_val("reaccept_ready", 32'(inst_ready), 32'd0);
    check_val("reaccept_we", 32'(write_en), 32'd0);
    tick();
    check_val("reaccept_rm", 32'(ReadMem), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_val("reaccept_we_wb", 32'(write_en), 32'd1);
    tick();
    check_val("reaccept_idle", 32'(inst_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
